afsk_delay_mult_disc: RTL and testbench
=======================================

Name: afsk_delay_mult_disc

Overview:
- Delay-and-multiply FSK discriminator.
- Sits directly downstream of the sample delay line. It takes the current sample x[n] and the delayed sample x[n-D], forms their product, and low-pass filters it with a WINDOW-sample moving sum.
- Outputs the filtered discriminator value and a hard mark/space bit to the bit-clock-recovery stage.

Parameters:
- WIDTH, 12, bit width of the signed input samples.
- WINDOW, 8, moving-sum length in samples; must be >= 2; need not be a power of two.
- HYST, 0, hysteresis threshold on |sum|. Used only when AFSK_HYST_EN is defined.
- Derived (localparams, not overridable): PROD_W = 2*WIDTH; ACC_W = PROD_W + $clog2(WINDOW).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset; clears all state.
- clken_i  input  1  clock enable; when low, every register holds its value.
- dvalid_i  input  1  input sample strobe; one sample per cycle in which dvalid_i & clken_i is high.
- data_i  input  WIDTH  current sample x[n], signed two's complement.
- delayed_i  input  WIDTH  delayed sample x[n-D], signed; aligned with data_i.
- sum_o  output  ACC_W  moving sum of the last WINDOW products, signed.
- bit_o  output  1  hard decision; 1 = sum non-negative (mark), 0 = negative (space).
- dvalid_o  output  1  one-cycle strobe: sum_o and bit_o are updated and the window is full.
- primed_o  output  1  high once WINDOW samples have entered since reset; stays high until reset.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - sum_o=0, bit_o=0, dvalid_o=0, primed_o=0.
  - Product register, stage valid flag, circular buffer (all WINDOW entries), write pointer and fill counter all cleared to 0.
- Clock enable: every register update is qualified by clken_i. When clken_i is low, dvalid_i is ignored and all outputs hold, including dvalid_o. Downstream qualifies dvalid_o with clken_i.
- Stage 1, edge T where dvalid_i & clken_i:
  - prod <= signed(data_i) * signed(delayed_i), full PROD_W bits, no truncation.
  - p_vld <= 1. Otherwise p_vld <= 0 on enabled edges.
- Stage 2, next enabled edge with p_vld=1:
  - acc <= acc + sext(prod) - sext(buf[wptr]).
  - buf[wptr] <= prod.
  - wptr <= (wptr == WINDOW-1) ? 0 : wptr+1.
  - fill <= min(fill+1, WINDOW).
- Outputs, on the same edge as stage 2:
  - sum_o <= new acc.
  - bit_o <= ~new_acc[ACC_W-1].
  - dvalid_o <= (fill+1 >= WINDOW).
  - primed_o <= primed_o | (fill+1 >= WINDOW).
  - On enabled edges without a stage 2 update, dvalid_o <= 0 and the other outputs hold.
- Latency: dvalid_o is high in the cycle after the second enabled edge following sample acceptance, i.e. 2 enabled clocks.
- Throughput: one sample per clock; back-to-back dvalid_i is fully supported, with no stall or backpressure.
- Before primed: sum_o and bit_o still update, because zero-filled buffer entries contribute 0, but dvalid_o stays 0.
- Arithmetic: the accumulator cannot overflow; |sum| <= WINDOW * 2^(2*WIDTH-2). The most negative product, (-2^(W-1))^2, is positive and fits in PROD_W.
- Wrap-around: the pointer wraps from WINDOW-1 to 0 with no gap; the oldest product is subtracted on the same edge it is overwritten.
- Reset mid-operation: all partial state is discarded, including a product in flight in stage 1. A fresh prime of WINDOW samples is required before the next dvalid_o.

Optional Feature:
- Macro: AFSK_HYST_EN.
- Defined:
  - bit_o <= 1 only when new_acc > HYST.
  - bit_o <= 0 only when new_acc < -HYST.
  - Otherwise bit_o holds its previous value (reset value 0).
- Not defined: bit_o = ~sign(new_acc); HYST is unused and no comparators are generated.

Test Plan:
- Reset: hold rst_n_i low while driving dvalid_i, clken_i, data_i and delayed_i -> sum_o=0, bit_o=0, dvalid_o=0, primed_o=0; release -> all still 0 until samples arrive.
- Priming (WINDOW=4): 4 back-to-back samples data=100, delayed=100 ->
  - sum_o steps 10000, 20000, 30000, 40000;
  - dvalid_o first high 2 clocks after the 4th dvalid_i, together with primed_o=1;
  - bit_o=1.
- Sliding window: continue with data=100, delayed=-100 -> sum_o 20000, 0, -20000, -40000; bit_o 1, 1, 0, 0; dvalid_o high on each.
- Extremes (WIDTH=12, WINDOW=4):
  - 4 samples of -2048 * -2048 -> sum_o=16777216, bit_o=1;
  - then 4 samples of 2047 * -2048 -> sum_o=-16769024, bit_o=0; no overflow.
- Clock enable: clken_i low for 3 cycles with dvalid_i high and data=500, delayed=500 -> no output change, dvalid_o stays 0, samples are not counted; clken_i high again -> pipeline resumes exactly where it stopped.
- Mid-operation reset:
  - after 2 samples, pulse rst_n_i low for 1 cycle -> outputs return to 0;
  - next dvalid_o only after 4 new samples;
  - with AFSK_HYST_EN and HYST=5000, a sum of 3000 after a mark keeps bit_o=1.

Source files
------------

// File: rtl/afsk_delay_mult_disc.sv
// ---------------------------------------------------------------------------
// afsk_delay_mult_disc
//   Delay-and-multiply FSK discriminator. Multiplies the current sample x[n]
//   by the delayed sample x[n-D], then low-pass filters the product with a
//   WINDOW-sample moving sum kept in a circular buffer. Emits the filtered
//   value and a hard mark/space decision.
//
//   Pipeline: stage 1 registers the product; stage 2 updates the moving sum
//   and the outputs. Result appears two enabled clocks after the sample.
//
//   Handshake: a sample is accepted on every rising edge where
//   clken_i & dvalid_i is high (no backpressure). dvalid_o is a one-cycle
//   strobe that must be qualified with clken_i downstream; it only rises
//   once the window is full.
//
//   Optional feature macro: AFSK_HYST_EN -- when defined, bit_o uses a
//   +/-HYST hysteresis band instead of the plain sign of the sum.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   clken_i    clock enable, all registers hold when low
//   dvalid_i   input sample strobe
//   data_i     x[n], signed WIDTH bits
//   delayed_i  x[n-D], signed WIDTH bits
//   sum_o      moving sum of last WINDOW products, signed ACC_W bits
//   bit_o      hard decision, 1 = mark (non-negative)
//   dvalid_o   output update strobe with full window
//   primed_o   sticky: window has been filled since reset
// ---------------------------------------------------------------------------
module afsk_delay_mult_disc #(
  parameter int WIDTH  = 12,
  parameter int WINDOW = 8,
  parameter int HYST   = 0,
  localparam int PROD_W = 2 * WIDTH,
  localparam int ACC_W  = PROD_W + $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             clken_i,
  input  logic             dvalid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] delayed_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             bit_o,
  output logic             dvalid_o,
  output logic             primed_o
);

  localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // Wide enough to hold WINDOW+1 so the fill+1 compare never wraps.
  localparam int CNT_W = $clog2(WINDOW + 2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (WINDOW < 2) begin : g_bad_window
    $error("afsk_delay_mult_disc: WINDOW must be >= 2");
  end
  if (HYST < 0) begin : g_bad_hyst
    $error("afsk_delay_mult_disc: HYST must be non-negative");
  end

`ifdef AFSK_HYST_EN
  localparam logic signed [ACC_W-1:0] HYST_P = ACC_W'(HYST);
  localparam logic signed [ACC_W-1:0] HYST_N = -HYST_P;
`endif

  logic        [PROD_W-1:0] prod_q, prod_d;
  logic                     p_vld_q, p_vld_d;
  logic        [PROD_W-1:0] win_q [WINDOW];
  logic        [PROD_W-1:0] win_d [WINDOW];
  logic        [PTR_W-1:0]  wptr_q, wptr_d;
  logic        [CNT_W-1:0]  fill_q, fill_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     bit_q, bit_d;
  logic                     dvalid_q, dvalid_d;
  logic                     primed_q, primed_d;

  // Sign-extended operands: the low PROD_W bits of their unsigned product
  // equal the full signed product.
  logic [PROD_W-1:0] data_ext, dly_ext;
  logic [ACC_W-1:0]  new_ext, old_ext;
  logic [CNT_W-1:0]  fill_inc;
  logic              full_now;

  always_comb begin
    data_ext = {{WIDTH{data_i[WIDTH-1]}}, data_i};
    dly_ext  = {{WIDTH{delayed_i[WIDTH-1]}}, delayed_i};
    new_ext  = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    old_ext  = {{(ACC_W-PROD_W){win_q[wptr_q][PROD_W-1]}}, win_q[wptr_q]};
    fill_inc = fill_q + CNT_ONE;
    full_now = (fill_inc >= CNT_FULL);

    prod_d   = prod_q;
    p_vld_d  = p_vld_q;
    win_d    = win_q;
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    dvalid_d = dvalid_q;
    primed_d = primed_q;

    if (clken_i) begin
      // Stage 1: register the product of an accepted sample.
      p_vld_d  = dvalid_i;
      if (dvalid_i) begin
        prod_d = data_ext * dly_ext;
      end
      dvalid_d = 1'b0;

      // Stage 2: the slot being overwritten holds the oldest product
      // (zero until the buffer has filled once), so subtract it now.
      if (p_vld_q) begin
        acc_d         = acc_q + $signed(new_ext) - $signed(old_ext);
        win_d[wptr_q] = prod_q;
        wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        fill_d        = (fill_q == CNT_FULL) ? fill_q : fill_inc;
        dvalid_d      = full_now;
        primed_d      = primed_q | full_now;
`ifdef AFSK_HYST_EN
        if (acc_d > HYST_P) begin
          bit_d = 1'b1;
        end else if (acc_d < HYST_N) begin
          bit_d = 1'b0;
        end
`else
        bit_d = ~acc_d[ACC_W-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q   <= '0;
      p_vld_q  <= 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        win_q[i] <= '0;
      end
      wptr_q   <= '0;
      fill_q   <= '0;
      acc_q    <= '0;
      bit_q    <= 1'b0;
      dvalid_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      p_vld_q  <= p_vld_d;
      win_q    <= win_d;
      wptr_q   <= wptr_d;
      fill_q   <= fill_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      dvalid_q <= dvalid_d;
      primed_q <= primed_d;
    end
  end

  assign sum_o    = acc_q;
  assign bit_o    = bit_q;
  assign dvalid_o = dvalid_q;
  assign primed_o = primed_q;

endmodule

// File: tb/tb_afsk_delay_mult_disc.sv
// ---------------------------------------------------------------------------
// tb_afsk_delay_mult_disc
//   Self-checking bench for afsk_delay_mult_disc (WIDTH=12, WINDOW=4).
//   Reference model: the expected sum is the plain arithmetic sum of the
//   last WINDOW accepted products, which become visible one enabled edge
//   after the edge that accepted them. Directed sequences cover priming,
//   sliding, extremes, clock-enable gaps and resets; then random traffic.
// ---------------------------------------------------------------------------
module tb_afsk_delay_mult_disc;

  localparam int WIDTH  = 12;
  localparam int WINDOW = 4;
  localparam int ACC_W  = 2 * WIDTH + $clog2(WINDOW);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n_i = 1'b1;
  logic             clken_i = 1'b0;
  logic             dvalid_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [WIDTH-1:0] delayed_i = '0;
  logic [ACC_W-1:0] sum_o;
  logic             bit_o;
  logic             dvalid_o;
  logic             primed_o;

  always #5 clk = ~clk;

  afsk_delay_mult_disc #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW),
    .HYST  (0)
  ) dut (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .clken_i  (clken_i),
    .dvalid_i (dvalid_i),
    .data_i   (data_i),
    .delayed_i(delayed_i),
    .sum_o    (sum_o),
    .bit_o    (bit_o),
    .dvalid_o (dvalid_o),
    .primed_o (primed_o)
  );

  // ---------------- scoreboard / model ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  logic signed [63:0] exp_q[$];   // products accepted, not yet visible
  logic signed [63:0] hist_q[$];  // last WINDOW visible products
  int                 n_seen;     // products visible since reset
  logic signed [63:0] exp_sum;
  logic               exp_bit, exp_dv, exp_pr;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    hist_q.delete();
    n_seen  = 0;
    exp_sum = 0;
    exp_bit = 1'b0;
    exp_dv  = 1'b0;
    exp_pr  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic v, input int d, input int dl);
    logic signed [63:0] p;
    if (!en) return;
    exp_dv = 1'b0;
    if (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      hist_q.push_back(p);
      if (hist_q.size() > WINDOW) void'(hist_q.pop_front());
      exp_sum = 0;
      foreach (hist_q[i]) exp_sum += hist_q[i];
      exp_bit = (exp_sum >= 0);
      n_seen++;
      exp_dv = (n_seen >= WINDOW);
      if (exp_dv) exp_pr = 1'b1;
    end
    if (v) exp_q.push_back(64'(d) * 64'(dl));
  endtask

  task automatic compare_all();
    check_val("sum",    $signed(sum_o), exp_sum);
    check_val("bit",    64'(bit_o),     64'(exp_bit));
    check_val("dvalid", 64'(dvalid_o),  64'(exp_dv));
    check_val("primed", 64'(primed_o),  64'(exp_pr));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic v, input int d, input int dl);
    @(negedge clk);
    clken_i   = en;
    dvalid_i  = v;
    data_i    = d[WIDTH-1:0];
    delayed_i = dl[WIDTH-1:0];
    @(posedge clk);
    #1;
    model_edge(en, v, d, dl);
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    int d;
    @(negedge clk);
    rst_n_i = 1'b0;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      clken_i   = 1'($urandom_range(1));
      dvalid_i  = 1'($urandom_range(1));
      d         = int'($urandom_range(4095));
      data_i    = d[WIDTH-1:0];
      d         = int'($urandom_range(4095));
      delayed_i = d[WIDTH-1:0];
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
    end
    rst_n_i  = 1'b1;
    clken_i  = 1'b0;
    dvalid_i = 1'b0;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    do_reset(3);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Priming: 100*100, then sliding with 100*-100.
    for (int i = 0; i < 4; i++) step(1, 1, 100, 100);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 100, -100);
      if (i == 0) begin
        check_val("prime_sum", $signed(sum_o), 64'sd40000);
        check_val("prime_dv", 64'(dvalid_o), 64'd1);
        check_val("prime_pr", 64'(primed_o), 64'd1);
      end
    end
    step(1, 0, 0, 0);
    check_val("slide_sum", $signed(sum_o), -64'sd40000);
    check_val("slide_bit", 64'(bit_o), 64'd0);

    // Extremes.
    for (int i = 0; i < 4; i++) step(1, 1, -2048, -2048);
    step(1, 0, 0, 0);
    check_val("ext_pos", $signed(sum_o), 64'sd16777216);
    for (int i = 0; i < 4; i++) step(1, 1, 2047, -2048);
    step(1, 0, 0, 0);
    check_val("ext_neg", $signed(sum_o), -64'sd16769024);
    check_val("ext_bit", 64'(bit_o), 64'd0);

    // Clock enable gap with a sample in flight.
    step(1, 1, 300, 7);
    for (int i = 0; i < 3; i++) step(0, 1, 500, 500);
    step(1, 1, -9, 40);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Mid-operation reset, then a fresh prime.
    step(1, 1, 100, 100);
    step(1, 1, 100, 100);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, 1, 50, 60);
    step(1, 0, 0, 0);
    check_val("reprime_sum", $signed(sum_o), 64'sd12000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(9) < 8), 1'($urandom_range(9) < 7), rnd_s(), rnd_s());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
